alu_ctrl_pipe: RTL and testbench
================================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2: buffer entries; power of 2, >= 2.
REQ-002 SHALL have parameter CNT_W, default 8: width of illegal-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept.
REQ-007 SHALL have port instruction  input  word_t  raw instruction.
REQ-008 SHALL have port alu_op  input  alu_op_t (2)  mode from control unit.
REQ-009 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head.
REQ-012 SHALL have port out_alu_ctrl  output  alu_ctrl_t  decoded operation of head.
REQ-013 SHALL have port out_illegal  output  1  head instruction undecodable.
REQ-014 SHALL have port out_instr  output  word_t  head instruction passthrough.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH+1)  entries held.
REQ-016 SHALL have port illegal_cnt  output  CNT_W  saturating count of illegal pushes.

Function
REQ-017 alu_op SHALL select mode: ALU_LDST (00) -> ADD; ALU_BR (01) -> branch decode; ALU_FUNCT (10) -> R/I decode; 11 -> illegal.
REQ-018 R-type (funct7 0000000), funct3 000/001/010/011/100/101/110/111 SHALL give ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; funct7 0100000 SHALL give SUB (000), SRA (101).
REQ-019 I-type SHALL decode as R-type except funct3 000 always ADD; funct3 101 uses funct7 for SRL/SRA; funct3 001 requires funct7 0000000.
REQ-020 Branch funct3 000/001 SHALL give SUB, 100/101 SLT, 110/111 SLTU; 010/011 illegal.
REQ-021 Any other funct7 or opcode in ALU_FUNCT mode SHALL set illegal=1, alu_ctrl=ADD.
REQ-022 Push occurs when in_valid && in_ready; pop when out_valid && out_ready.
REQ-023 in_ready SHALL equal (occupancy < DEPTH), independent of out_ready in that cycle.
REQ-024 Entry pushed at edge N SHALL appear at head with out_valid=1 after edge N (1-cycle latency) if buffer was empty.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; order strictly FIFO.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 When empty, out_valid=0, out_alu_ctrl=ADD, out_illegal=0, out_instr=0.
REQ-028 flush SHALL empty the buffer at next edge and take priority over a same-cycle push and pop; illegal_cnt unaffected.
REQ-029 illegal_cnt SHALL increment on each push with illegal=1 (flush cycles excluded), saturating at 2^CNT_W-1.

Reset
REQ-030 rst low SHALL immediately clear pointers, occupancy=0, out_valid=0, illegal_cnt=0, in_ready=1; outputs per REQ-027.
REQ-031 Reset mid-transfer SHALL discard all entries; no partial entry survives.

Configuration
REQ-032 Macro ALU_CTRL_MEXT_EN defined: R-type funct7 0000001 SHALL decode funct3 000/001/011/100/101/110/111 to MUL/MULH/MULHU/DIV/DIVU/REM/REMU; funct3 010 illegal.
REQ-033 Macro undefined: funct7 0000001 SHALL be illegal; M encodings never produced.

Structure
REQ-034 RISCV_pkg SHALL hold alu_ctrl_t (5-bit, M encodings always reserved), alu_op_t, opcode_t including BRANCH (1100011) and OP_IMM.
REQ-035 Decode SHALL be one combinational sub-module alu_ctrl_dec (instruction, alu_op -> alu_ctrl, illegal); buffer and counter in alu_ctrl_pipe.

Verification
REQ-036 alu_op=10, instr 0x40B50533 (sub), out_ready=1 -> next cycle out_valid=1, out_alu_ctrl=SUB, out_illegal=0.
REQ-037 alu_op=01, instr 0x00B54463 (blt) -> SLT; 0x00B56463 (bltu) -> SLTU; alu_op=00 any instr -> ADD.
REQ-038 out_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after 2nd, occupancy=2, 3rd not accepted; then out_ready=1 -> entries in order.
REQ-039 Full buffer, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0.
REQ-040 instr 0x02B50533 (mul): with ALU_CTRL_MEXT_EN -> MUL; without -> illegal=1, illegal_cnt increments; CNT_W=2 and 5 illegal pushes -> illegal_cnt=3.
REQ-041 Assert rst low while occupancy=2 -> immediately out_valid=0, occupancy=0, illegal_cnt=0.

Source files
------------

// File: rtl/RISCV_pkg.sv
// Shared RISC-V decode types for the ALU control pipeline.
// M-extension ALU codes are always reserved here; whether they are produced is set by ALU_CTRL_MEXT_EN.
package RISCV_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        ALU_LDST  = 2'b00,
        ALU_BR    = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_IMM   = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_STORE = 7'b0100011,
        OP       = 7'b0110011,
        OP_LUI   = 7'b0110111,
        BRANCH   = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111
    } opcode_t;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_MUL   = 5'd10,
        ALU_MULH  = 5'd11,
        ALU_MULHU = 5'd12,
        ALU_DIV   = 5'd13,
        ALU_DIVU  = 5'd14,
        ALU_REM   = 5'd15,
        ALU_REMU  = 5'd16
    } alu_ctrl_t;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // One buffered instruction with its decode captured at push time.
    typedef struct packed {
        word_t     instr;
        alu_ctrl_t ctrl;
        logic      illegal;
    } entry_t;

    // Base integer op for a funct3 when funct7 selects the primary encoding.
    function automatic alu_ctrl_t base_op(input logic [2:0] funct3);
        alu_ctrl_t op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_pipe_dec.sv
// Combinational ALU control decoder: instruction + alu_op -> alu_ctrl, illegal.
// Define ALU_CTRL_MEXT_EN to decode R-type funct7=0000001 as M-extension ops.
module alu_ctrl_dec
    import RISCV_pkg::*;
(
    input  word_t     instruction,
    input  alu_op_t   alu_op,
    output alu_ctrl_t alu_ctrl,
    output logic      illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (alu_op)
            ALU_LDST: alu_ctrl = ALU_ADD;
            ALU_BR: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl = ALU_SLTU;
                    default:        illegal  = 1'b1;
                endcase
            end
            ALU_FUNCT: begin
                if (opcode == OP) begin
                    if (funct7 == F7_BASE) begin
                        alu_ctrl = base_op(funct3);
                    end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                        alu_ctrl = ALU_SUB;
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        alu_ctrl = ALU_SRA;
`ifdef ALU_CTRL_MEXT_EN
                    end else if (funct7 == F7_MEXT) begin
                        case (funct3)
                            3'b000:  alu_ctrl = ALU_MUL;
                            3'b001:  alu_ctrl = ALU_MULH;
                            3'b011:  alu_ctrl = ALU_MULHU;
                            3'b100:  alu_ctrl = ALU_DIV;
                            3'b101:  alu_ctrl = ALU_DIVU;
                            3'b110:  alu_ctrl = ALU_REM;
                            3'b111:  alu_ctrl = ALU_REMU;
                            default: illegal  = 1'b1;
                        endcase
`else
                    end else if (funct7 == F7_MEXT) begin
                        illegal = 1'b1;
`endif
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (opcode == OP_IMM) begin
                    // funct7 only qualifies the shift immediates; other I-types carry imm bits there
                    case (funct3)
                        3'b000: alu_ctrl = ALU_ADD;
                        3'b001: begin
                            if (funct7 == F7_BASE) alu_ctrl = ALU_SLL;
                            else                   illegal  = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     alu_ctrl = ALU_SRL;
                            else if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
                            else                       illegal  = 1'b1;
                        end
                        default: alu_ctrl = base_op(funct3);
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) alu_ctrl = ALU_ADD;
    end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Decoded-instruction FIFO: decodes on push, buffers DEPTH entries, counts illegal pushes.
// Optional M-extension decode is enabled with ALU_CTRL_MEXT_EN (see alu_ctrl_dec).
module alu_ctrl_pipe
    import RISCV_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  word_t                      instruction,
    input  alu_op_t                    alu_op,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output alu_ctrl_t                  out_alu_ctrl,
    output logic                       out_illegal,
    output word_t                      out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           illegal_cnt
);

    // Handshake: a beat transfers on a rising edge where valid && ready;
    // in_ready depends only on occupancy, never on out_ready.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] cnt;

    alu_ctrl_t dec_ctrl;
    logic      dec_illegal;
    logic      push;
    logic      pop;
    entry_t    head;

    alu_ctrl_dec u_dec (
        .instruction (instruction),
        .alu_op      (alu_op),
        .alu_ctrl    (dec_ctrl),
        .illegal     (dec_illegal)
    );

    assign in_ready  = (occ < FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: every output read from it is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{instr: instruction, ctrl: dec_ctrl, illegal: dec_illegal};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (push && !flush && dec_illegal && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign head         = mem[rd_ptr];
    assign out_alu_ctrl = out_valid ? head.ctrl : ALU_ADD;
    assign out_illegal  = out_valid ? head.illegal : 1'b0;
    assign out_instr    = out_valid ? head.instr : '0;
    assign occupancy    = occ;
    assign illegal_cnt  = cnt;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed scenarios then random traffic against a queue-based model.
// Expected decode follows ALU_CTRL_MEXT_EN the same way the build does.
module tb_alu_ctrl_pipe;
    import RISCV_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    word_t                      instruction;
    alu_op_t                    alu_op;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    alu_ctrl_t                  out_alu_ctrl;
    logic                       out_illegal;
    word_t                      out_instr;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CNT_W-1:0]           illegal_cnt;

    // Scoreboard entry: {illegal, ctrl[4:0], instr[31:0]}
    logic [37:0] exp_q[$];
    int          model_cnt;
    int          checks;
    int          failures;

    alu_ctrl_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .alu_op       (alu_op),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_ctrl (out_alu_ctrl),
        .out_illegal  (out_illegal),
        .out_instr    (out_instr),
        .occupancy    (occupancy),
        .illegal_cnt  (illegal_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {illegal, ctrl}; built from lookup tables of the ISA encodings.
    function automatic logic [5:0] model_dec(input logic [31:0] ins, input logic [1:0] op);
        alu_ctrl_t  base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        alu_ctrl_t  mext [8] = '{ALU_MUL, ALU_MULH, ALU_ADD, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        alu_ctrl_t  br   [8] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
        int         f3;
        int         f7;
        int         opc;
        bit         mext_on;
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        opc = int'(ins[6:0]);
`ifdef ALU_CTRL_MEXT_EN
        mext_on = 1'b1;
`else
        mext_on = 1'b0;
`endif
        if (op == 2'd0) return {1'b0, ALU_ADD};
        if (op == 2'd3) return {1'b1, ALU_ADD};
        if (op == 2'd1) begin
            if (f3 == 2 || f3 == 3) return {1'b1, ALU_ADD};
            return {1'b0, br[f3]};
        end
        if (opc == 'h33) begin
            if (f7 == 0) return {1'b0, base[f3]};
            if (f7 == 'h20 && f3 == 0) return {1'b0, ALU_SUB};
            if (f7 == 'h20 && f3 == 5) return {1'b0, ALU_SRA};
            if (f7 == 1 && mext_on && f3 != 2) return {1'b0, mext[f3]};
            return {1'b1, ALU_ADD};
        end
        if (opc == 'h13) begin
            if (f3 == 0) return {1'b0, ALU_ADD};
            if (f3 == 1) return (f7 == 0) ? {1'b0, ALU_SLL} : {1'b1, ALU_ADD};
            if (f3 == 5) begin
                if (f7 == 0) return {1'b0, ALU_SRL};
                if (f7 == 'h20) return {1'b0, ALU_SRA};
                return {1'b1, ALU_ADD};
            end
            return {1'b0, base[f3]};
        end
        return {1'b1, ALU_ADD};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [37:0] head;
        head = {1'b0, ALU_ADD, 32'h0};
        if (exp_q.size() != 0) head = exp_q[0];
        chk("in_ready", 38'(in_ready), 38'(exp_q.size() < DEPTH));
        chk("out_valid", 38'(out_valid), 38'(exp_q.size() != 0));
        chk("occupancy", 38'(occupancy), 38'(exp_q.size()));
        chk("illegal_cnt", 38'(illegal_cnt), 38'(model_cnt));
        chk("out_instr", 38'(out_instr), 38'(head[31:0]));
        chk("out_alu_ctrl", 38'(out_alu_ctrl), 38'(head[36:32]));
        chk("out_illegal", 38'(out_illegal), 38'(head[37]));
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; drives one cycle, checks, advances the model, returns at next posedge+1.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [1:0] op,
                         input bit fl, input bit ordy);
        bit         push;
        bit         pop;
        logic [5:0] d;
        in_valid    = v;
        instruction = ins;
        alu_op      = alu_op_t'(op);
        flush       = fl;
        out_ready   = ordy;
        #2;
        check_outputs();
        push = v && (exp_q.size() < DEPTH);
        pop  = ordy && (exp_q.size() != 0);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                d = model_dec(ins, op);
                exp_q.push_back({d, ins});
                if (d[5] && model_cnt < CNT_MAX) model_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [6:0]  opc;
        logic [2:0]  f3;
        r  = $urandom();
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        case ($urandom_range(0, 3))
            0:       opc = 7'h33;
            1:       opc = 7'h13;
            2:       opc = 7'h63;
            default: opc = 7'($urandom_range(0, 127));
        endcase
        return {f7, r[9:0], f3, r[14:10], opc};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        model_cnt   = 0;
        in_valid    = 1'b0;
        instruction = '0;
        alu_op      = ALU_LDST;
        flush       = 1'b0;
        out_ready   = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // sub through R-type decode, 1-cycle latency
        cycle(1, 32'h40B50533, 2'd2, 0, 1);
        chk("sub_valid", 38'(out_valid), 38'(1));
        chk("sub_ctrl", 38'(out_alu_ctrl), 38'(ALU_SUB));
        chk("sub_illegal", 38'(out_illegal), 38'(0));

        // branch and load/store modes
        cycle(1, 32'h00B54463, 2'd1, 0, 1);
        chk("blt_ctrl", 38'(out_alu_ctrl), 38'(ALU_SLT));
        cycle(1, 32'h00B56463, 2'd1, 0, 1);
        chk("bltu_ctrl", 38'(out_alu_ctrl), 38'(ALU_SLTU));
        cycle(1, 32'hDEADBEEF, 2'd0, 0, 1);
        chk("ldst_ctrl", 38'(out_alu_ctrl), 38'(ALU_ADD));
        chk("ldst_illegal", 38'(out_illegal), 38'(0));
        cycle(0, 32'h0, 2'd0, 0, 1);
        chk("drained_valid", 38'(out_valid), 38'(0));

        // back-pressure: third push refused, then drained in order
        cycle(1, 32'h00B50533, 2'd2, 0, 0);
        cycle(1, 32'h00B51533, 2'd2, 0, 0);
        chk("full_in_ready", 38'(in_ready), 38'(0));
        chk("full_occupancy", 38'(occupancy), 38'(2));
        cycle(1, 32'h00B57533, 2'd2, 0, 0);
        chk("third_refused", 38'(occupancy), 38'(2));
        cycle(0, 32'h0, 2'd0, 0, 1);
        cycle(0, 32'h0, 2'd0, 0, 1);
        cycle(0, 32'h0, 2'd0, 0, 1);

        // flush beats a same-cycle push and pop
        cycle(1, 32'h00B50533, 2'd2, 0, 0);
        cycle(1, 32'h00B54533, 2'd2, 0, 0);
        cycle(1, 32'h00B56533, 2'd2, 1, 1);
        chk("flush_occupancy", 38'(occupancy), 38'(0));
        chk("flush_valid", 38'(out_valid), 38'(0));

        // mul and illegal-counter saturation
        cycle(1, 32'h02B50533, 2'd2, 0, 1);
`ifdef ALU_CTRL_MEXT_EN
        chk("mul_ctrl", 38'(out_alu_ctrl), 38'(ALU_MUL));
        chk("mul_cnt", 38'(illegal_cnt), 38'(0));
`else
        chk("mul_illegal", 38'(out_illegal), 38'(1));
        chk("mul_cnt", 38'(illegal_cnt), 38'(1));
`endif
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h00000033, 2'd3, 0, 1);
        chk("cnt_saturated", 38'(illegal_cnt), 38'(CNT_MAX));

        // asynchronous reset with a full buffer
        cycle(1, 32'h00B50533, 2'd3, 0, 0);
        cycle(1, 32'h00B50533, 2'd2, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_valid", 38'(out_valid), 38'(0));
        chk("rst_occupancy", 38'(occupancy), 38'(0));
        chk("rst_cnt", 38'(illegal_cnt), 38'(0));
        chk("rst_in_ready", 38'(in_ready), 38'(1));
        do_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle(bit'($urandom_range(0, 3) != 0), rand_instr(),
                      2'($urandom_range(0, 3)), bit'($urandom_range(0, 29) == 0),
                      bit'($urandom_range(0, 2) != 0));
            end
        end
        cycle(0, 32'h0, 2'd0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
